// File: rtl/uart_pkg.sv
// Shared UART constants and helpers, used by both the Rx and Tx baud generators.
//   CLK_FREQ_DEFAULT : default system clock frequency in Hz
//   OVERSAMPLE       : sample-clock cycles per bit period
//   BAUD_*           : supported line rates
//   baud_sel_t       : 2-bit run-time rate select encoding
//   half_period()    : rounded half-period of the oversampled baud clock, in system clocks
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEFAULT = 50_000_000;
  localparam int unsigned OVERSAMPLE       = 16;

  localparam int unsigned BAUD_2400  = 2400;
  localparam int unsigned BAUD_4800  = 4800;
  localparam int unsigned BAUD_9600  = 9600;
  localparam int unsigned BAUD_19200 = 19200;

  typedef enum logic [1:0] {
    SEL_2400  = 2'b00,
    SEL_4800  = 2'b01,
    SEL_9600  = 2'b10,
    SEL_19200 = 2'b11
  } baud_sel_t;

  // round(clk_freq / (2*oversample*baud)) using integer arithmetic
  function automatic int unsigned half_period(
    input int unsigned baud,
    input int unsigned clk_freq   = CLK_FREQ_DEFAULT,
    input int unsigned oversample = OVERSAMPLE
  );
    return (clk_freq + oversample * baud) / (2 * oversample * baud);
  endfunction

endpackage

// File: rtl/baud_divider.sv
// Generic counter/toggler.
//   clock    : system clock, rising edge
//   reset    : synchronous active-high reset; clears count and output
//   restart  : clears the count without touching the output level
//   terminal : last count value; at terminal the count wraps and div_clk toggles
//   div_clk  : registered square wave, period 2*(terminal+1) clocks
module baud_divider (
  input  logic        clock,
  input  logic        reset,
  input  logic        restart,
  input  logic [15:0] terminal,
  output logic        div_clk
);

  logic [15:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count   <= '0;
      div_clk <= 1'b0;
    end else if (restart) begin
      count   <= '0;
    end else if (count >= terminal) begin
      // >= rather than == so a shrinking terminal can never let the count run away
      count   <= '0;
      div_clk <= ~div_clk;
    end else begin
      count   <= count + 16'd1;
    end
  end

endmodule

// File: rtl/baud_sampling.sv
// Rx baud sample-clock generator: divides the system clock into a square wave
// at OVERSAMPLE x the selected baud rate.
//   clock     : system clock, rising edge
//   reset_n   : synchronous reset, active HIGH despite the name
//   baud_rate : rate select 00=2400, 01=4800, 10=9600, 11=19200
//   baud_clk  : registered 16x-baud square wave
module baud_sampling
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = uart_pkg::CLK_FREQ_DEFAULT,
  parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] baud_rate,
  output logic       baud_clk
);

  localparam logic [15:0] TERM_2400  = 16'(half_period(BAUD_2400,  CLK_FREQ, OVERSAMPLE) - 1);
  localparam logic [15:0] TERM_4800  = 16'(half_period(BAUD_4800,  CLK_FREQ, OVERSAMPLE) - 1);
  localparam logic [15:0] TERM_9600  = 16'(half_period(BAUD_9600,  CLK_FREQ, OVERSAMPLE) - 1);
  localparam logic [15:0] TERM_19200 = 16'(half_period(BAUD_19200, CLK_FREQ, OVERSAMPLE) - 1);

  baud_sel_t   sel_q;
  logic        sel_change;
  logic [15:0] terminal;

  assign sel_change = (baud_rate != sel_q);

  always_ff @(posedge clock) begin
    if (reset_n) begin
      sel_q <= baud_sel_t'(baud_rate);
    end else if (sel_change) begin
      sel_q <= baud_sel_t'(baud_rate);
    end
  end

  // Terminal comes from the registered select, so the change cycle only
  // restarts the count and the new rate takes effect from the next cycle.
  always_comb begin
    terminal = TERM_2400;
    case (sel_q)
      SEL_2400:  terminal = TERM_2400;
      SEL_4800:  terminal = TERM_4800;
      SEL_9600:  terminal = TERM_9600;
      SEL_19200: terminal = TERM_19200;
      default:   terminal = TERM_2400;
    endcase
  end

  baud_divider u_div (
    .clock    (clock),
    .reset    (reset_n),
    .restart  (sel_change),
    .terminal (terminal),
    .div_clk  (baud_clk)
  );

endmodule

// File: tb/tb_baud_sampling.sv
module tb_baud_sampling;

  logic       clock;
  logic       reset_n;
  logic [1:0] baud_rate;
  logic       baud_clk;

  baud_sampling dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .baud_rate (baud_rate),
    .baud_clk  (baud_clk)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  typedef struct {
    int   cyc;
    logic level;
  } exp_t;

  exp_t sb[$];

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   toggles = 0;
  int   t0 = 0, t1 = 0, t2 = 0;
  logic mon_en = 1'b0;
  logic prev   = 1'b0;

  // half periods for select 00..11 at 50 MHz, 16x oversampling
  int half_tab [4] = '{651, 326, 163, 81};

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard monitor: every toggle of baud_clk must match the next expected entry
  always @(negedge clock) begin
    if (mon_en && (baud_clk !== prev)) begin
      exp_t e;
      prev = baud_clk;
      toggles++;
      t0 = t1; t1 = t2; t2 = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_toggle: cyc=%0d level=%b, required no toggle", cyc, baud_clk);
      end else begin
        e = sb.pop_front();
        if (e.cyc !== cyc || e.level !== baud_clk) begin
          errors++;
          $display("FAIL toggle: cyc=%0d level=%b, required cyc=%0d level=%b",
                   cyc, baud_clk, e.cyc, e.level);
        end
      end
    end
  end

  task automatic push_exp(input int c, input logic lv);
    exp_t e;
    e.cyc = c;
    e.level = lv;
    sb.push_back(e);
  endtask

  task automatic run_until(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d pending toggles, required 0 (next cyc=%0d)",
               name, sb.size(), sb[0].cyc);
      sb.delete();
    end
  endtask

  task automatic do_reset(input int cycles, input logic [1:0] sel, output int rel);
    mon_en = 1'b0;
    @(negedge clock);
    baud_rate = sel;
    reset_n   = 1'b1;
    repeat (cycles) @(negedge clock);
    reset_n = 1'b0;
    rel     = cyc;
    prev    = baud_clk;
    mon_en  = 1'b1;
  endtask

  task automatic test_reset;
    int rel;
    do_reset(5, 2'b00, rel);
    checks++;
    if (baud_clk !== 1'b0) begin
      errors++; $display("FAIL reset_clk: got %b, required 0", baud_clk);
    end
    checks++;
    if (dut.u_div.count !== 16'd0) begin
      errors++; $display("FAIL reset_count: got %0d, required 0", dut.u_div.count);
    end
    push_exp(rel + 651, 1'b1);
    push_exp(rel + 1302, 1'b0);
    push_exp(rel + 1953, 1'b1);
    @(negedge clock);
    checks++;
    if (baud_clk !== 1'b0) begin
      errors++; $display("FAIL first_clock: got %b, required 0", baud_clk);
    end
    run_until(rel + 1955);
    check_drained("reset");
  endtask

  task automatic test_sweep;
    int   rel, base, h;
    logic lv;
    do_reset(1, 2'b00, rel);
    for (int s = 0; s < 4; s++) begin
      h = half_tab[s];
      if (s == 0) begin
        base = rel;
      end else begin
        baud_rate = 2'(s);
        base = cyc + 1;
      end
      lv = ~baud_clk;
      for (int k = 1; k <= 4; k++) begin
        push_exp(base + k * h, lv);
        lv = ~lv;
      end
      run_until(base + 4 * h + 2);
      check_drained("sweep");
      checks++;
      if ((t2 - t0) !== 2 * h) begin
        errors++;
        $display("FAIL sweep_period sel=%0d: got %0d clocks, required %0d", s, t2 - t0, 2 * h);
      end
    end
  endtask

  task automatic test_sel_change;
    int rel;
    // 00 -> 11 with count at 400
    do_reset(1, 2'b00, rel);
    run_until(rel + 400);
    baud_rate = 2'b11;
    push_exp(rel + 401 + 81, 1'b1);
    @(negedge clock);
    checks++;
    if (baud_clk !== 1'b0) begin
      errors++; $display("FAIL change_hold: got %b, required 0", baud_clk);
    end
    run_until(rel + 401 + 81 + 2);
    check_drained("change400");
    // 11 -> 00 exactly when count is at the old terminal: the toggle is suppressed
    do_reset(1, 2'b11, rel);
    run_until(rel + 80);
    baud_rate = 2'b00;
    push_exp(rel + 81 + 651, 1'b1);
    run_until(rel + 81 + 651 + 2);
    check_drained("change_terminal");
  endtask

  task automatic test_mid_reset;
    int rel, rel2;
    do_reset(1, 2'b01, rel);
    push_exp(rel + 326, 1'b1);
    run_until(rel + 400);
    check_drained("pre_mid_reset");
    checks++;
    if (baud_clk !== 1'b1) begin
      errors++; $display("FAIL mid_reset_pre: got %b, required 1", baud_clk);
    end
    mon_en  = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (baud_clk !== 1'b0) begin
      errors++; $display("FAIL mid_reset_clear: got %b, required 0", baud_clk);
    end
    reset_n = 1'b0;
    rel2    = cyc;
    prev    = baud_clk;
    mon_en  = 1'b1;
    push_exp(rel2 + 326, 1'b1);
    run_until(rel2 + 330);
    check_drained("mid_reset");
  endtask

  task automatic test_long_run;
    int   rel;
    logic lv;
    do_reset(1, 2'b11, rel);
    toggles = 0;
    lv = 1'b1;
    for (int k = 1; k <= 123; k++) begin
      push_exp(rel + 81 * k, lv);
      lv = ~lv;
    end
    run_until(rel + 10000);
    checks++;
    if (toggles !== 123) begin
      errors++; $display("FAIL long_toggles: got %0d, required 123", toggles);
    end
    check_drained("long");
  endtask

  initial begin
    reset_n   = 1'b1;
    baud_rate = 2'b00;
    test_reset();
    test_sweep();
    test_sel_change();
    test_mid_reset();
    test_long_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
